// File: rtl/mem_loader_pkg.sv
// Shared constants for the memory loader: state encoding, memory depth and
// header width. Imported by the RTL and by the bench.
package mem_loader_pkg;

    localparam int MEM_DEPTH = 4096;  // words in the target memory
    localparam int ADDR_W    = 12;    // log2(MEM_DEPTH)
    localparam int HDR_W     = 16;    // big-endian word-count header

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_BYTE,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/mem_loader_word_assembler.sv
// word_assembler: collects four bytes, most significant first, into a word.
// Ports:
//   i_clock, i_reset   clock and synchronous active-high reset
//   i_clear            clears byte index and shift register (new load)
//   i_shift            shift i_byte_in into the low byte
//   i_byte_in          incoming byte
//   o_word_out         assembled word (held while no shift occurs)
//   o_full             the next shifted byte completes a word (index == 3)
module word_assembler
    import mem_loader_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte_in,
    output logic [31:0] o_word_out,
    output logic        o_full
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_idx  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_shift) begin
            r_word <= {r_word[23:0], i_byte_in};
            r_idx  <= r_idx + 2'd1;  // wraps to 0 after the fourth byte
        end
    end

    assign o_word_out = r_word;
    assign o_full     = (r_idx == 2'd3);

endmodule

// File: rtl/mem_loader.sv
// mem_loader: loads a byte stream (16-bit big-endian word count, then
// 4 bytes per word, MSB first) into a level-sensitive memory port.
// Each word goes through SETUP (addr/data valid), WRITE (wen=1), HOLD
// (wen=0) so addr/data never move while wen is high.
// Ports:
//   i_clock, i_reset     clock and synchronous active-high reset
//   i_start              begins a load from IDLE/DONE/ERROR
//   i_in_valid/i_in_data byte stream, o_in_ready its ready
//   o_mem_addr/din/wen/ren  memory port (ren tied 0)
//   o_busy/o_done/o_error   status
//   o_words_written      words whose write pulse has completed
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = MEM_DEPTH
)(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_din,
    output logic        o_mem_wen,
    output logic        o_mem_ren,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_words_written
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [HDR_W:0]    MAX_CNT = (HDR_W+1)'(MAX_WORDS);

    state_t              r_state;
    logic [HDR_W-1:0]    r_hdr;
    logic [15:0]         r_ww;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;

    logic                w_idle_like;
    logic                w_accept;
    logic                w_full;
    logic [31:0]         w_word;
    logic [HDR_W-1:0]    w_count;
    logic [15:0]         w_ww_next;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                         (r_state == ST_ERROR);
    assign w_accept    = o_in_ready && i_in_valid;
    // Full count as seen on the edge that accepts the low header byte.
    assign w_count     = {r_hdr[15:8], i_in_data};
    assign w_ww_next   = r_ww + 16'd1;

    word_assembler u_asm (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (w_idle_like && i_start),
        .i_shift    (w_accept && (r_state == ST_BYTE)),
        .i_byte_in  (i_in_data),
        .o_word_out (w_word),
        .o_full     (w_full)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_hdr   <= '0;
            r_ww    <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        r_state <= ST_HDR0;
                        r_hdr   <= '0;
                        r_ww    <= '0;
                    end
                end
                ST_HDR0: begin
                    if (i_in_valid) begin
                        r_hdr[15:8] <= i_in_data;
                        r_state     <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (i_in_valid) begin
                        r_hdr[7:0] <= i_in_data;
                        if (w_count == '0)
                            r_state <= ST_DONE;
                        else if ({1'b0, w_count} > MAX_CNT)
                            r_state <= ST_ERROR;
                        else
                            r_state <= ST_BYTE;
                    end
                end
                ST_BYTE: begin
                    // Address is latched with the last byte so it is
                    // already valid throughout SETUP.
                    if (i_in_valid && w_full) begin
                        r_addr  <= BASE_A + r_ww[ADDR_W-1:0];
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_wen   <= 1'b1;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wen   <= 1'b0;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    r_ww    <= w_ww_next;
                    r_state <= (w_ww_next == r_hdr) ? ST_DONE : ST_BYTE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready      = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                             (r_state == ST_BYTE);
    assign o_busy          = o_in_ready || (r_state == ST_SETUP) ||
                             (r_state == ST_WRITE) || (r_state == ST_HOLD);
    assign o_done          = (r_state == ST_DONE);
    assign o_error         = (r_state == ST_ERROR);
    assign o_mem_addr      = {{(32-ADDR_W){1'b0}}, r_addr};
    // The assembler does not shift outside BYTE, so the word is stable
    // from SETUP through HOLD.
    assign o_mem_din       = w_word;
    assign o_mem_wen       = r_wen;
    assign o_mem_ren       = 1'b0;
    assign o_words_written = r_ww;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: two instances share stimulus, one at BASE_ADDR 0 and
// one at MEM_DEPTH-2. Expected writes are queued by the stimulus and checked
// by a monitor on every write-enable pulse.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int B2 = MEM_DEPTH - 2;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] din;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        rdy  [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic        wen  [2];
    logic        ren  [2];
    logic        busy [2];
    logic        done [2];
    logic        err  [2];
    logic [15:0] ww   [2];

    int  n_pass = 0;
    int  n_total = 0;
    int  cyc = 0;
    logic abort = 1'b0;
    wr_t exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_loader #(.BASE_ADDR(0)) dut0 (
        .i_clock(clock), .i_reset(reset), .i_start(start),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(rdy[0]),
        .o_mem_addr(addr[0]), .o_mem_din(din[0]), .o_mem_wen(wen[0]),
        .o_mem_ren(ren[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_error(err[0]), .o_words_written(ww[0]));

    mem_loader #(.BASE_ADDR(B2)) dut1 (
        .i_clock(clock), .i_reset(reset), .i_start(start),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(rdy[1]),
        .o_mem_addr(addr[1]), .o_mem_din(din[1]), .o_mem_wen(wen[1]),
        .o_mem_ren(ren[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_error(err[1]), .o_words_written(ww[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Status vector: {in_ready, busy, done, error, wen, ren}
    task automatic chk_status(input string name, input logic [5:0] exp);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s_stat%0d", name, k),
                {26'd0, rdy[k], busy[k], done[k], err[k], wen[k], ren[k]}, {26'd0, exp});
    endtask

    task automatic chk_idle(input string name);
        chk_status(name, 6'b000000);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_addr%0d", name, k), addr[k], 32'd0);
            chk($sformatf("%s_din%0d", name, k), din[k], 32'd0);
            chk($sformatf("%s_ww%0d", name, k), {16'd0, ww[k]}, 32'd0);
        end
    endtask

    task automatic chk_ww(input string name, input int exp);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s_ww%0d", name, k), {16'd0, ww[k]}, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Presents one byte, waits (bounded) for ready, returns on the negedge
    // after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!rdy[0] && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!rdy[0]) fail("byte_ready_timeout");
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic wait_done(output int at);
        int n = 0;
        while (!done[0] && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!done[0]) fail("done_timeout");
        at = cyc;
    endtask

    // Monitor: every wen pulse must match the queue head; addr/din must
    // equal the SETUP values and remain through HOLD; wen lasts one cycle.
    logic [31:0] p_addr [2];
    logic [31:0] p_din  [2];
    logic [31:0] h_addr [2];
    logic [31:0] h_din  [2];
    logic        hold_chk = 1'b0;

    always @(negedge clock) begin
        if (hold_chk) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("hold_wen%0d", k), {31'd0, wen[k]}, 32'd0);
                chk($sformatf("hold_addr%0d", k), addr[k], h_addr[k]);
                chk($sformatf("hold_din%0d", k), din[k], h_din[k]);
            end
        end
        hold_chk <= 1'b0;
        if (wen[0] || wen[1]) begin
            chk("wen0", {31'd0, wen[0]}, 32'd1);
            chk("wen1", {31'd0, wen[1]}, 32'd1);
            if (exp_q.size() == 0) begin
                fail("unexpected_write");
            end else begin
                wr_t e;
                logic [11:0] a2;
                e  = exp_q.pop_front();
                a2 = 12'(e.idx + 32'(B2));
                chk("wr_addr0", addr[0], e.idx);
                chk("wr_din0", din[0], e.din);
                chk("wr_addr1", addr[1], {20'd0, a2});
                chk("wr_din1", din[1], e.din);
            end
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("setup_addr%0d", k), addr[k], p_addr[k]);
                chk($sformatf("setup_din%0d", k), din[k], p_din[k]);
            end
            if (!abort) hold_chk <= 1'b1;
            h_addr <= addr;
            h_din  <= din;
        end
        p_addr <= addr;
        p_din  <= din;
    end

    initial begin
        int t_hdr, t_last, t_done;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clock);
        chk_idle("in_reset");
        reset = 1'b0;
        @(negedge clock);
        chk_idle("idle");

        // Two words, in_valid held high; second instance writes 4094/4095.
        pulse_start();
        chk_status("hdr0", 6'b110000);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        t_hdr = cyc;
        exp_q.push_back('{32'd0, 32'hDEADBEEF});
        exp_q.push_back('{32'd1, 32'h01234567});
        send_word(32'hDEADBEEF, 0);
        send_word(32'h01234567, 0);
        t_last = cyc;
        wait_done(t_done);
        chk("lat_from_hdr", t_done - t_hdr, 32'd14);
        chk("lat_from_last", t_done - t_last, 32'd3);
        chk_status("done2", 6'b001000);
        chk_ww("done2", 2);
        chk("addr_hi", {12'd0, addr[1][31:12]}, 32'd0);

        // Zero count: done the cycle after HDR1, counter cleared by start.
        pulse_start();
        chk_ww("restart", 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk_status("zero", 6'b001000);

        // 4097 words: rejected.
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        chk_status("over", 6'b000100);
        repeat (5) @(negedge clock);
        chk_status("over_hold", 6'b000100);

        // Exactly 4096 words: accepted, waiting for data.
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        chk_status("max", 6'b110000);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_idle("after_max");

        // Stalled stream, with a start pulse mid-word that must be ignored.
        pulse_start();
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        exp_q.push_back('{32'd0, 32'hAABBCCDD});
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        pulse_start();
        send_byte(8'hCC, 1);
        send_byte(8'hDD, 1);
        wait_done(t_done);
        chk_ww("stall", 1);

        // Reset during WRITE: write abandoned, next load restarts at 0.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        exp_q.push_back('{32'd0, 32'h11223344});
        send_word(32'h11223344, 0);
        abort = 1'b1;
        @(negedge clock);
        chk_status("in_write", 6'b010010);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_idle("rst_write");
        abort = 1'b0;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        exp_q.push_back('{32'd0, 32'hCAFEF00D});
        send_word(32'hCAFEF00D, 0);
        wait_done(t_done);
        chk_ww("after_rst", 1);

        repeat (3) @(negedge clock);
        chk("writes_pending", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
